// File: rtl/shift_sequencer.sv
// Command-driven sequencer for the load/rotate shift register.
// Optional macro SHIFTSEQ_AMOUNT_REDUCE_EN trims shift amounts at accept.
module shift_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_amount,
   output logic             sh_load_n,
   output logic             sh_rotate_right,
   output logic             sh_as_right,
   output logic [WIDTH-1:0] sh_data,
   input  logic [WIDTH-1:0] sh_q,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] result_data,
   output logic             busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [1:0]       op_r;
   logic [WIDTH-1:0] data_r;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] amt_eff;

`ifdef SHIFTSEQ_AMOUNT_REDUCE_EN
   localparam logic [CNT_W-1:0] AMT_MAX = CNT_W'(WIDTH - 1);

   // Rotations wrap every WIDTH steps; an ASR saturates after WIDTH-1.
   always_comb begin
      amt_eff = cmd_amount;
      unique case (cmd_op)
         2'b00, 2'b01: amt_eff = cmd_amount & AMT_MAX;
         2'b10: amt_eff = (cmd_amount > AMT_MAX) ? AMT_MAX : cmd_amount;
         default: amt_eff = '0;
      endcase
   end
`else
   always_comb begin
      amt_eff = cmd_amount;
      if (cmd_op == 2'b11) amt_eff = '0;
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         op_r        <= 2'b00;
         data_r      <= '0;
         cnt         <= '0;
         result_data <= '0;
      end else begin
         state <= state_nxt;
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  op_r   <= cmd_op;
                  data_r <= cmd_data;
                  cnt    <= amt_eff;
               end
            end
            SHIFT: begin
               if (cnt == '0) result_data <= sh_q;
               else cnt <= cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // The shifter never holds, so its controls are only meaningful in LOAD/SHIFT.
   always_comb begin
      state_nxt       = state;
      sh_load_n       = 1'b1;
      sh_rotate_right = 1'b0;
      sh_as_right     = 1'b0;
      unique case (state)
         IDLE: begin
            if (cmd_valid) state_nxt = LOAD;
         end
         LOAD: begin
            sh_load_n = 1'b0;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            sh_rotate_right = (op_r == 2'b01) || (op_r == 2'b10);
            sh_as_right     = (op_r == 2'b10);
            if (cnt == '0) state_nxt = DONE;
         end
         DONE: begin
            if (result_ready) state_nxt = IDLE;
         end
      endcase
   end

   assign sh_data      = data_r;
   assign cmd_ready    = (state == IDLE);
   assign result_valid = (state == DONE);
   assign busy         = (state != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural 4-bit shifter attached.
// Expected results and latencies are hand-computed.
module tb_shift_sequencer;

   logic       clock = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [3:0] cmd_data;
   logic [2:0] cmd_amount;
   logic       sh_load_n;
   logic       sh_rotate_right;
   logic       sh_as_right;
   logic [3:0] sh_data;
   logic [3:0] sh_q = 4'b0000;
   logic       result_valid;
   logic       result_ready;
   logic [3:0] result_data;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
      .clock           (clock),
      .reset           (reset),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_op          (cmd_op),
      .cmd_data        (cmd_data),
      .cmd_amount      (cmd_amount),
      .sh_load_n       (sh_load_n),
      .sh_rotate_right (sh_rotate_right),
      .sh_as_right     (sh_as_right),
      .sh_data         (sh_data),
      .sh_q            (sh_q),
      .result_valid    (result_valid),
      .result_ready    (result_ready),
      .result_data     (result_data),
      .busy            (busy)
   );

   always #5 clock = ~clock;

   // Load/rotate shift register: moves on every edge, no hold mode.
   always @(posedge clock) begin
      if (!sh_load_n) sh_q <= sh_data;
      else if (sh_rotate_right && sh_as_right) sh_q <= {sh_q[3], sh_q[3:1]};
      else if (sh_rotate_right) sh_q <= {sh_q[0], sh_q[3:1]};
      else sh_q <= {sh_q[2:0], sh_q[3]};
   end

   task automatic expect_eq(input string tag, input int got, input int want);
      n_checks++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Issue one command, measure latency, then hand the result off after
   // holding result_ready low for `hold` cycles.
   task automatic run_cmd(input string tag, input logic [1:0] op,
                          input logic [3:0] data, input logic [2:0] amt,
                          input logic [3:0] want, input int want_lat,
                          input int want_rr, input int hold);
      int lat;
      int rr;
      int w;
      w = 0;
      while (!cmd_ready && w < 20) begin
         tick();
         w++;
      end
      expect_eq({tag, " ready"}, int'(cmd_ready), 1);
      cmd_valid  = 1'b1;
      cmd_op     = op;
      cmd_data   = data;
      cmd_amount = amt;
      tick();
      cmd_valid = 1'b0;
      cmd_data  = 4'b0000;
      lat = 0;
      rr  = int'(sh_rotate_right);
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (result_valid) begin
            lat = k;
            break;
         end
         rr += int'(sh_rotate_right);
      end
      expect_eq({tag, " latency"}, lat, want_lat);
      expect_eq({tag, " rotR cycles"}, rr, want_rr);
      expect_eq({tag, " result"}, int'(result_data), int'(want));
      for (int k = 0; k < hold; k++) begin
         cmd_valid = (k == 2);
         tick();
         cmd_valid = 1'b0;
         expect_eq({tag, " hold data"}, int'(result_data), int'(want));
         expect_eq({tag, " hold valid"}, int'(result_valid), 1);
         expect_eq({tag, " hold cmd_ready"}, int'(cmd_ready), 0);
      end
      result_ready = 1'b1;
      tick();
      result_ready = 1'b0;
      expect_eq({tag, " after valid"}, int'(result_valid), 0);
      expect_eq({tag, " after cmd_ready"}, int'(cmd_ready), 1);
      expect_eq({tag, " after busy"}, int'(busy), 0);
   endtask

   initial begin
      reset        = 1'b1;
      cmd_valid    = 1'b0;
      cmd_op       = 2'b00;
      cmd_data     = 4'b0000;
      cmd_amount   = 3'd0;
      result_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      expect_eq("reset cmd_ready", int'(cmd_ready), 1);
      expect_eq("reset result_valid", int'(result_valid), 0);
      expect_eq("reset result_data", int'(result_data), 0);
      expect_eq("reset busy", int'(busy), 0);
      expect_eq("reset load_n", int'(sh_load_n), 1);
      expect_eq("reset sh_data", int'(sh_data), 0);

      run_cmd("ror1", 2'b01, 4'b1001, 3'd1, 4'b1100, 3, 2, 0);
      run_cmd("asr_neg", 2'b10, 4'b1000, 3'd2, 4'b1110, 4, 3, 0);
      run_cmd("asr_pos", 2'b10, 4'b0110, 3'd2, 4'b0001, 4, 3, 0);
      run_cmd("rol3", 2'b00, 4'b0001, 3'd3, 4'b1000, 5, 0, 0);
      run_cmd("load", 2'b11, 4'b1010, 3'd7, 4'b1010, 2, 0, 0);
      run_cmd("bp", 2'b01, 4'b0110, 3'd2, 4'b1001, 4, 3, 5);

      // Abandon a command in its second SHIFT cycle.
      cmd_valid  = 1'b1;
      cmd_op     = 2'b01;
      cmd_data   = 4'b0101;
      cmd_amount = 3'd5;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      expect_eq("mid busy", int'(busy), 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      expect_eq("rst busy", int'(busy), 0);
      expect_eq("rst result_valid", int'(result_valid), 0);
      expect_eq("rst cmd_ready", int'(cmd_ready), 1);
      expect_eq("rst result_data", int'(result_data), 0);
      run_cmd("post_rst", 2'b01, 4'b0011, 3'd1, 4'b1001, 3, 2, 0);

`ifdef SHIFTSEQ_AMOUNT_REDUCE_EN
      run_cmd("ror5", 2'b01, 4'b1001, 3'd5, 4'b1100, 3, 2, 0);
`else
      run_cmd("ror5", 2'b01, 4'b1001, 3'd5, 4'b1100, 7, 6, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
